error_check_controller: RTL

Sequencing controller for the error-checker datapath, which computes E = Y*(B0 + X*B1). On `start` it clears the datapath's E register and streams `n_points` samples from the sample memory through the datapath. It then checks the sign of every E result and counts misclassified points (E <= 0, signed). It sits between the top-level training FSM, which issues start/done, and the datapath and sample memory.

---
 rtl/error_check_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/error_check_controller.sv
// Sequencing controller for the E = Y*(B0 + X*B1) error-checker datapath.
// Streams n_points samples, then counts points whose E result is <= 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; err_count / all_correct hold
// S_CLEAR | clear datapath E register, error count and address index
// S_RUN   | one sample per cycle, mem_addr = 0 .. n_points-1
// S_FLUSH | extra en2 pulse pushes the last point's result into E
// S_LAST  | final E evaluated
// S_DONE  | one-cycle done pulse, all_correct updated
module error_check_controller #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   n_points,
  input  logic [19:0]       E,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              en2,
  output logic              ld_er,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic              all_correct
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_LAST, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] N_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          eval_q, eval_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                all_correct_q, all_correct_d;
  logic                mem_rd_q, mem_rd_d;
  logic                en2_q, en2_d;
  logic                ld_er_q, ld_er_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                eval_hit;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    addr_d        = addr_q;
    eval_d        = {eval_q[0], mem_rd_q};
    err_d         = err_q;
    all_correct_d = all_correct_q;

    // Misclassified: E negative or exactly zero; count saturates.
    eval_hit = eval_q[1] && (E[19] || (E == '0));
    if (eval_hit && (err_q != '1)) err_d = err_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n_points;
          addr_d = '0;
          if (n_points == '0) begin
            state_d       = S_DONE;
            err_d         = '0;
            all_correct_d = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        addr_d  = '0;
        err_d   = '0;
        eval_d  = '0;
      end
      S_RUN: begin
        if ({1'b0, addr_q} == (n_q - N_ONE)) state_d = S_FLUSH;
        else                                 addr_d  = addr_q + ADDR_W'(1);
      end
      S_FLUSH: state_d = S_LAST;
      S_LAST: begin
        state_d       = S_DONE;
        all_correct_d = (err_d == '0);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are decoded from the next state.
    ld_er_d  = (state_d == S_CLEAR);
    en2_d    = (state_d == S_RUN) || (state_d == S_FLUSH);
    mem_rd_d = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      addr_q        <= '0;
      eval_q        <= '0;
      err_q         <= '0;
      all_correct_q <= 1'b1;
      mem_rd_q      <= 1'b0;
      en2_q         <= 1'b0;
      ld_er_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      addr_q        <= addr_d;
      eval_q        <= eval_d;
      err_q         <= err_d;
      all_correct_q <= all_correct_d;
      mem_rd_q      <= mem_rd_d;
      en2_q         <= en2_d;
      ld_er_q       <= ld_er_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = mem_rd_q;
  assign en2         = en2_q;
  assign ld_er       = ld_er_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_q;
  assign all_correct = all_correct_q;

endmodule
